muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply / divide / modulo execution unit for the multicycle
//   controller. MUL uses LSB-first shift-add. DIV and MOD use MSB-first
//   restoring division. Each operation takes 32 iterations: done pulses
//   33 cycles after start is accepted. Divide-by-zero and unsupported
//   opcodes skip the iterations, so done pulses on the next cycle.
//
//   Optional build macro: MULDIV_SIGNED_EN
//     Defined   : operands are two's complement. The core works on
//                 magnitudes, and the result sign is applied on the way
//                 into DONE.
//     Undefined : all operations are unsigned.
//
// Ports
//   clk     in   system clock; all state updates on posedge
//   reset   in   synchronous, active-high reset
//   start   in   request; sampled only in IDLE
//   opcode  in   [4:0] operation select, sampled with start
//   alu0    in   [31:0] multiplicand / dividend, sampled with start
//   alu1    in   [31:0] multiplier / divisor, sampled with start
//   busy    out  high in CALC and DONE
//   done    out  one-cycle pulse; result/err valid in this cycle
//   result  out  [31:0] product low word, quotient or remainder (held)
//   err     out  divide-by-zero or unsupported opcode (held with result)
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter logic [4:0] OP_MUL = 5'd16,
    parameter logic [4:0] OP_DIV = 5'd17,
    parameter logic [4:0] OP_MOD = 5'd18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] alu0,
    input  logic [31:0] alu1,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [4:0]  r_op;
    logic [31:0] r_a;      // MUL: shifted multiplicand; DIV: dividend in, quotient out
    logic [31:0] r_b;      // MUL: shifted multiplier;   DIV: divisor
    logic [31:0] r_acc;    // MUL: product accumulator;  DIV: partial remainder
    logic [31:0] r_result;
    logic        r_err;
`ifdef MULDIV_SIGNED_EN
    logic        r_neg;    // negate the unsigned core result in DONE
`endif

    logic        w_supported;
    logic        w_div_zero;
    logic [31:0] w_mag0;
    logic [31:0] w_mag1;
    logic        w_neg_in;
    logic [32:0] w_rem_shift;
    logic        w_q_bit;
    logic [31:0] w_a_nxt;
    logic [31:0] w_b_nxt;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_raw;
    logic [31:0] w_final;

    // NOTE: every signal in this block gets a default first, so that no path
    //       leaves a variable unassigned and infers a latch.
    always_comb begin
        w_supported = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
        w_div_zero  = ((opcode == OP_DIV) || (opcode == OP_MOD)) && (alu1 == 32'd0);

`ifdef MULDIV_SIGNED_EN
        w_mag0   = alu0[31] ? (32'd0 - alu0) : alu0;
        w_mag1   = alu1[31] ? (32'd0 - alu1) : alu1;
        // A remainder follows the dividend's sign. A product or quotient is
        // negative when the two operand signs differ.
        w_neg_in = (opcode == OP_MOD) ? alu0[31] : (alu0[31] ^ alu1[31]);
`else
        w_mag0   = alu0;
        w_mag1   = alu1;
        w_neg_in = 1'b0;
`endif

        // Restoring-division step: bring in the next dividend bit, then
        // subtract when it fits. After a subtract the remainder is below the
        // divisor, so it always fits in 32 bits.
        w_rem_shift = {r_acc, r_a[31]};
        w_q_bit     = (w_rem_shift >= {1'b0, r_b});

        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_acc_nxt = r_acc;
        if (r_op == OP_MUL) begin
            w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
            w_a_nxt   = {r_a[30:0], 1'b0};
            w_b_nxt   = {1'b0, r_b[31:1]};
        end else begin
            w_acc_nxt = w_q_bit ? (w_rem_shift[31:0] - r_b) : w_rem_shift[31:0];
            w_a_nxt   = {r_a[30:0], w_q_bit};
        end

        w_raw = (r_op == OP_DIV) ? w_a_nxt : w_acc_nxt;
`ifdef MULDIV_SIGNED_EN
        w_final = r_neg ? (32'd0 - w_raw) : w_raw;
`else
        w_final = w_raw;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    //       registers then update together at the edge, with no
    //       ordering races between blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_op     <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 32'd0;
            r_result <= 32'd0;
            r_err    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_supported) begin
                            r_result <= 32'd0;
                            r_err    <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_div_zero) begin
                            // Raw alu0 is returned for MOD, including in the
                            // signed build.
                            r_result <= (opcode == OP_DIV) ? 32'hFFFF_FFFF : alu0;
                            r_err    <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_op    <= opcode;
                            r_a     <= w_mag0;
                            r_b     <= w_mag1;
                            r_acc   <= 32'd0;
                            r_count <= 5'd31;
`ifdef MULDIV_SIGNED_EN
                            r_neg   <= w_neg_in;
`endif
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_acc <= w_acc_nxt;
                    if (r_count == 5'd0) begin
                        // Last iteration: its outcome goes straight into
                        // the output registers, so there is no extra cycle.
                        r_result <= w_final;
                        r_err    <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef MULDIV_SIGNED_EN
    logic w_unused;
    assign w_unused = w_neg_in;
`endif

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit. Each issued operation pushes its
//   hand-computed result, err and expected done cycle into a queue. A
//   monitor on the falling edge pops one entry and compares it whenever
//   done is high.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [4:0] OP_MUL = 5'd16;
    localparam logic [4:0] OP_DIV = 5'd17;
    localparam logic [4:0] OP_MOD = 5'd18;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] alu0;
    logic [31:0] alu1;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    muldiv_unit #(.OP_MUL(OP_MUL), .OP_DIV(OP_DIV), .OP_MOD(OP_MOD)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .alu0   (alu0),
        .alu1   (alu1),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("err", 32'(err), 32'(e.err));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] res, input logic e, input int at);
        exp_t x;
        x.res = res;
        x.err = e;
        x.cyc = at;
        sb.push_back(x);
    endtask

    // Present one request for a single cycle. The current cycle is t.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic e, input int lat);
        opcode = op;
        alu0   = a;
        alu1   = b;
        start  = 1'b1;
        push(res, e, cyc + lat);
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 5'd0;
        alu0   = 32'd0;
        alu1   = 32'd0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // MUL 7*6 with busy timing
        t0 = cyc;
        issue(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33);
        check("mul_busy_t1", 32'(busy), 32'd1);
        while (cyc < t0 + 34) tick();
        check("mul_busy_t34", 32'(busy), 32'd0);
        check("mul_result_held", result, 32'd42);
        wait_done();

        // DIV 100/7 then MOD 100/7, start held high throughout
        t0 = cyc;
        opcode = OP_DIV;
        alu0   = 32'd100;
        alu1   = 32'd7;
        start  = 1'b1;
        push(32'd14, 1'b0, t0 + 33);
        tick();
        opcode = OP_MOD;
        push(32'd2, 1'b0, t0 + 67);
        while (cyc < t0 + 35) tick();
        start = 1'b0;
        wait_done();

        // Divide by zero and unsupported opcode: one-cycle latency
        issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done();
        issue(OP_MOD, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        wait_done();
        issue(5'd3, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        wait_done();

        // MUL overflow with input churn during CALC
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        for (int i = 0; i < 20; i++) begin
            start  = 1'($urandom_range(1, 0));
            opcode = (i % 2 == 0) ? OP_DIV : OP_MOD;
            alu0   = $urandom;
            alu1   = $urandom;
            tick();
        end
        start = 1'b0;
        wait_done();

        // Boundary divides
        issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        wait_done();
        issue(OP_MOD, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 1'b0, 33);
        wait_done();
        issue(OP_DIV, 32'd7, 32'd100, 32'd0, 1'b0, 33);
        wait_done();

`ifdef MULDIV_SIGNED_EN
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        wait_done();
        issue(OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        wait_done();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        wait_done();
        issue(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        wait_done();
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33);
        wait_done();
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, 33);
        wait_done();
        issue(OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0, 33);
        wait_done();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        wait_done();
        issue(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        wait_done();
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33);
        wait_done();
`endif

        // Reset abort: DIV started, reset at t+10; no done may follow
        t0 = cyc;
        opcode = OP_DIV;
        alu0   = 32'd1000;
        alu1   = 32'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        while (cyc < t0 + 10) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_err", 32'(err), 32'd0);
        repeat (40) tick();
        check("abort_idle", 32'(busy), 32'd0);

        issue(OP_MUL, 32'd3, 32'd3, 32'd9, 1'b0, 33);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
